// File: rtl/coderom_arbiter.sv
// Code ROM arbiter: shares a 4-bank x 8K x 16 synchronous ROM between the CPU
// port (C) and the self-test/debug port (D). C has priority; D is forced in after
// MAX_CPU consecutive C grants while it waits.
module coderom_arbiter #(
    parameter int unsigned ROM_LAT = 1,  // 1..3 edges from address/ce to valid rom_q
    parameter int unsigned MAX_CPU = 4   // 1..15 C grants before a waiting D is forced
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic [14:0] c_addr,
    output logic [15:0] c_data,
    output logic        c_ack,
    input  logic        d_req,
    input  logic [14:0] d_addr,
    output logic [15:0] d_data,
    output logic        d_ack,
    output logic [12:0] rom_a,
    output logic [3:0]  rom_ce_n,
    input  logic [15:0] rom_q,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StAddr, StCapt} state_e;
    typedef enum logic [1:0] {OwnNone, OwnC, OwnD} owner_e;

    localparam logic [1:0] LatLast   = 2'(ROM_LAT - 1);
    localparam logic [3:0] StarveMax = 4'(MAX_CPU);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic        abort_q, abort_d;
    logic [3:0]  starve_q, starve_d;
    logic [12:0] rom_a_q, rom_a_d;
    logic [3:0]  rom_ce_n_q, rom_ce_n_d;
    logic [15:0] c_data_q, c_data_d;
    logic [15:0] d_data_q, d_data_d;
    logic        c_ack_q, c_ack_d;
    logic        d_ack_q, d_ack_d;

    logic        c_elig, d_elig;
    logic        grant_c, grant_d;
    logic        owner_req;
    logic [14:0] sel_addr;

    // Arbitration, access sequencing and starvation bookkeeping
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lat_cnt_d  = lat_cnt_q;
        abort_d    = abort_q;
        rom_a_d    = rom_a_q;
        rom_ce_n_d = rom_ce_n_q;
        c_data_d   = c_data_q;
        d_data_d   = d_data_q;
        c_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        // The starvation count only means anything while D is actually waiting
        starve_d   = d_req ? starve_q : 4'd0;

        // A port whose ack is showing has not yet had a chance to drop its request
        c_elig   = c_req && !c_ack_q;
        d_elig   = d_req && !d_ack_q;
        grant_c  = c_elig && !(d_elig && (starve_q == StarveMax));
        grant_d  = d_elig && !grant_c;
        sel_addr = grant_c ? c_addr : d_addr;

        unique case (owner_q)
            OwnC:    owner_req = c_req;
            OwnD:    owner_req = d_req;
            default: owner_req = 1'b0;
        endcase

        unique case (state_q)
            StIdle: begin
                if (grant_c || grant_d) begin
                    owner_d    = grant_c ? OwnC : OwnD;
                    rom_a_d    = sel_addr[12:0];
                    rom_ce_n_d = ~(4'b0001 << sel_addr[14:13]);
                    lat_cnt_d  = 2'd0;
                    abort_d    = 1'b0;
                    state_d    = StAddr;
                end
                if (grant_d) begin
                    starve_d = 4'd0;
                end else if (grant_c && d_req && (starve_q != StarveMax)) begin
                    starve_d = starve_q + 4'd1;
                end
            end
            StAddr: begin
                if (!owner_req) abort_d = 1'b0 | 1'b1;
                if (lat_cnt_q == LatLast) begin
                    state_d = StCapt;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            StCapt: begin
                // Data is captured even for an abandoned access; only the ack is withheld
                if (owner_q == OwnC) begin
                    c_data_d = rom_q;
                    c_ack_d  = c_req && !abort_q;
                end else if (owner_q == OwnD) begin
                    d_data_d = rom_q;
                    d_ack_d  = d_req && !abort_q;
                end
                rom_ce_n_d = 4'hF;
                owner_d    = OwnNone;
                state_d    = StIdle;
            end
            default: begin
                rom_ce_n_d = 4'hF;
                owner_d    = OwnNone;
                state_d    = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= OwnNone;
            lat_cnt_q  <= 2'd0;
            abort_q    <= 1'b0;
            starve_q   <= 4'd0;
            rom_a_q    <= 13'd0;
            rom_ce_n_q <= 4'hF;
            c_data_q   <= 16'd0;
            d_data_q   <= 16'd0;
            c_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lat_cnt_q  <= lat_cnt_d;
            abort_q    <= abort_d;
            starve_q   <= starve_d;
            rom_a_q    <= rom_a_d;
            rom_ce_n_q <= rom_ce_n_d;
            c_data_q   <= c_data_d;
            d_data_q   <= d_data_d;
            c_ack_q    <= c_ack_d;
            d_ack_q    <= d_ack_d;
        end
    end

    assign rom_a    = rom_a_q;
    assign rom_ce_n = rom_ce_n_q;
    assign c_data   = c_data_q;
    assign d_data   = d_data_q;
    assign c_ack    = c_ack_q;
    assign d_ack    = d_ack_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_coderom_arbiter.sv
// Directed bench for coderom_arbiter with a registered 4-bank ROM model.
module tb_coderom_arbiter;

    logic        clk;
    logic        reset;
    logic        c_req;
    logic [14:0] c_addr;
    logic [15:0] c_data;
    logic        c_ack;
    logic        d_req;
    logic [14:0] d_addr;
    logic [15:0] d_data;
    logic        d_ack;
    logic [12:0] rom_a;
    logic [3:0]  rom_ce_n;
    logic [15:0] rom_q;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    coderom_arbiter #(
        .ROM_LAT (1),
        .MAX_CPU (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .c_req    (c_req),
        .c_addr   (c_addr),
        .c_data   (c_data),
        .c_ack    (c_ack),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_data   (d_data),
        .d_ack    (d_ack),
        .rom_a    (rom_a),
        .rom_ce_n (rom_ce_n),
        .rom_q    (rom_q),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: word = {0, bank, address}, registered one edge after ce/address
    always_ff @(posedge clk) begin
        case (rom_ce_n)
            4'b1110: rom_q <= {1'b0, 2'd0, rom_a};
            4'b1101: rom_q <= {1'b0, 2'd1, rom_a};
            4'b1011: rom_q <= {1'b0, 2'd2, rom_a};
            4'b0111: rom_q <= {1'b0, 2'd3, rom_a};
            default: rom_q <= 16'hDEAD;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic d_read(input logic [14:0] addr, input logic [3:0] exp_ce,
                          input logic [15:0] exp_data);
        int n;
        d_addr = addr;
        d_req  = 1'b1;
        step();
        check("d_ce_n", rom_ce_n, exp_ce);
        n = 0;
        while (!d_ack && n < 10) begin
            step();
            n++;
        end
        check("d_ack_latency", n, 2);
        check("d_data", d_data, exp_data);
        d_req = 1'b0;
        step();
        check("d_ack_pulse", d_ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] ack_vec;
        logic [9:0]  seq;
        logic [3:0]  prev_ce;
        logic        prev_ack;
        int          consec, ng, c_cnt, n_cack, n_dack, both, ack_seen;
        logic        busy_after;

        reset  = 1'b1;
        c_req  = 1'b0;
        d_req  = 1'b0;
        c_addr = '0;
        d_addr = '0;
        step();
        step();
        check("rst_ce_n", rom_ce_n, 4'hF);
        check("rst_rom_a", rom_a, 0);
        check("rst_c_data", c_data, 0);
        check("rst_d_data", d_data, 0);
        check("rst_acks", {c_ack, d_ack}, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        step();

        // Reset in the middle of an access
        c_addr = 15'h1234;
        c_req  = 1'b1;
        step();
        check("t1_busy_addr", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("t1_async_ce_n", rom_ce_n, 4'hF);
        check("t1_async_busy", busy, 0);
        check("t1_async_acks", {c_ack, d_ack}, 0);
        c_req = 1'b0;
        #2 reset = 1'b0;
        step();
        step();
        step();
        check("t1_idle_busy", busy, 0);
        check("t1_idle_ce_n", rom_ce_n, 4'hF);
        check("t1_no_update", c_data, 0);

        // Single C read; address change after grant must not matter
        c_addr = 15'h2ABC;
        c_req  = 1'b1;
        step();
        check("t2_ce_n", rom_ce_n, 4'b1101);
        check("t2_rom_a", rom_a, 13'h0ABC);
        check("t2_ack_e0", c_ack, 0);
        c_addr = 15'h7777;
        step();
        check("t2_ack_e1", c_ack, 0);
        check("t2_busy_e1", busy, 1);
        step();
        check("t2_ack_e2", c_ack, 1);
        check("t2_c_data", c_data, 16'h2ABC);
        check("t2_busy_e2", busy, 0);
        check("t2_ce_idle", rom_ce_n, 4'hF);
        c_req = 1'b0;
        step();
        check("t2_ack_pulse", c_ack, 0);
        check("t2_c_data_hold", c_data, 16'h2ABC);

        // Bank sweep through D
        d_read(15'h0000, 4'b1110, 16'h0000);
        d_read(15'h2000, 4'b1101, 16'h2000);
        d_read(15'h4000, 4'b1011, 16'h4000);
        d_read(15'h7FFF, 4'b0111, 16'h7FFF);

        // Abort: C drops its request during ADDR
        c_addr = 15'h5555;
        c_req  = 1'b1;
        step();
        check("t5_ce_n", rom_ce_n, 4'b1011);
        c_req      = 1'b0;
        ack_seen   = 0;
        busy_after = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (c_ack) ack_seen = 1;
            if (k == 2) busy_after = busy;
        end
        check("t5_no_ack", ack_seen, 0);
        check("t5_busy_after_capt", busy_after, 0);
        check("t5_c_data", c_data, 16'h5555);

        // Held request: one access every four cycles
        c_addr   = 15'h0F0F;
        c_req    = 1'b1;
        ack_vec  = '0;
        prev_ack = 1'b0;
        consec   = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            ack_vec[k-1] = c_ack;
            if (c_ack && prev_ack) consec++;
            prev_ack = c_ack;
        end
        c_req = 1'b0;
        check("t6_ack_pattern", ack_vec, 12'h444);
        check("t6_no_consec", consec, 0);
        check("t6_c_data", c_data, 16'h0F0F);
        for (int k = 0; k < 4; k++) step();
        check("t6_idle", busy, 0);

        // Starvation: C re-requests after every (aborted) access, D holds on
        c_addr  = 15'h0123;
        d_addr  = 15'h6456;
        c_req   = 1'b1;
        d_req   = 1'b1;
        prev_ce = 4'hF;
        seq     = '0;
        ng      = 0;
        c_cnt   = 0;
        n_cack  = 0;
        n_dack  = 0;
        both    = 0;
        for (int cyc = 0; cyc < 100 && ng < 10; cyc++) begin
            step();
            if (c_cnt == 2) begin
                c_req = 1'b0;
                c_cnt = 1;
            end else if (c_cnt == 1) begin
                c_req = 1'b1;
                c_cnt = 0;
            end
            if (c_ack) n_cack++;
            if (d_ack) n_dack++;
            if (c_ack && d_ack) both++;
            if (prev_ce == 4'hF && rom_ce_n != 4'hF) begin
                if (rom_ce_n == 4'b1110) begin
                    seq[ng] = 1'b0;
                    c_cnt   = 2;
                end else begin
                    seq[ng] = 1'b1;
                end
                ng++;
            end
            prev_ce = rom_ce_n;
        end
        c_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (c_ack) n_cack++;
            if (c_ack && d_ack) both++;
            if (d_ack) begin
                n_dack++;
                break;
            end
        end
        d_req = 1'b0;
        step();
        step();
        check("t4_grant_count", ng, 10);
        check("t4_grant_order", seq, 10'h210);
        check("t4_c_acks", n_cack, 0);
        check("t4_d_acks", n_dack, 2);
        check("t4_both_acks", both, 0);
        check("t4_d_data", d_data, 16'h6456);
        check("t4_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
